// File: rtl/mdu_if.sv
// mdu_if: E/D-stage request and HI/LO result bundle between pipeline and multiply/divide unit
interface mdu_if;
    logic [2:0]  e_md_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_md_use;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output e_md_op, e_rs, e_rt, d_md_use,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  e_md_op, e_rs, e_rt, d_md_use,
        output busy, stall_req, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO multiply/divide controller with fixed-latency busy window and pipeline stall request
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = ($clog2(MAXC + 1) > 4) ? $clog2(MAXC + 1) : 4;
    localparam logic [CW-1:0] MC = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DC = CW'(DIV_CYCLES);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0] hi, lo, p_hi, p_lo;
    logic [31:0] hi_n, lo_n, p_hi_n, p_lo_n;
    logic        sgn, a_neg, b_neg;
    logic [63:0] prod;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, q_res, r_res;
    logic        is_mul, is_div;

    assign is_mul        = (bus.e_md_op == OP_MULT) || (bus.e_md_op == OP_MULTU);
    assign is_div        = (bus.e_md_op == OP_DIV) || (bus.e_md_op == OP_DIVU);
    assign bus.busy      = (state == RUN);
    assign bus.stall_req = bus.d_md_use & (bus.busy | is_mul | is_div);
    assign bus.hi        = hi;
    assign bus.lo        = lo;

    // Operand datapath: sign-extended product, and division on magnitudes with sign fix-up
    // so that the most-negative / -1 case wraps to 0x80000000 with a zero remainder.
    always_comb begin
        sgn    = (bus.e_md_op == OP_MULT) || (bus.e_md_op == OP_DIV);
        a_neg  = sgn & bus.e_rs[31];
        b_neg  = sgn & bus.e_rt[31];
        prod   = {{32{a_neg}}, bus.e_rs} * {{32{b_neg}}, bus.e_rt};
        a_mag  = a_neg ? -bus.e_rs : bus.e_rs;
        b_mag  = b_neg ? -bus.e_rt : bus.e_rt;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        q_res  = (a_neg ^ b_neg) ? -q_mag : q_mag;
        r_res  = a_neg ? -r_mag : r_mag;
    end

    // Next-state logic: start ops only from IDLE, commit pending result on the final RUN edge.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hi_n    = hi;
        lo_n    = lo;
        p_hi_n  = p_hi;
        p_lo_n  = p_lo;
        if (state == RUN) begin
            cnt_n = cnt - 1'b1;
            if (cnt == CW'(1)) begin
                hi_n    = p_hi;
                lo_n    = p_lo;
                state_n = IDLE;
            end
        end else if (is_mul) begin
            {p_hi_n, p_lo_n} = prod;
            cnt_n   = MC;
            state_n = RUN;
        end else if (is_div) begin
            p_hi_n  = (bus.e_rt == 32'd0) ? hi : r_res;
            p_lo_n  = (bus.e_rt == 32'd0) ? lo : q_res;
            cnt_n   = DC;
            state_n = RUN;
        end else if (bus.e_md_op == OP_MTHI) begin
            hi_n = bus.e_rs;
        end else if (bus.e_md_op == OP_MTLO) begin
            lo_n = bus.e_rs;
        end
    end

    // State and architectural register update; reset overrides any op at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            hi    <= hi_n;
            lo    <= lo_n;
            p_hi  <= p_hi_n;
            p_lo  <= p_lo_n;
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: table vectors, corner sequences and random traffic against a behavioural HI/LO model
module tb_mdu_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    mdu_if bus();

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit valid = 1'b0;
    int left = 0;
    logic [31:0] mhi, mlo, phi, plo;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        longint a, b, p;
        logic [63:0] u;
        if (rst) begin
            left = 0;
            mhi = 0; mlo = 0; phi = 0; plo = 0;
        end else if (left > 0) begin
            left--;
            if (left == 0) begin
                mhi = phi;
                mlo = plo;
            end
        end else begin
            case (op)
                3'd1: begin
                    p = longint'($signed(rs)) * longint'($signed(rt));
                    {phi, plo} = p;
                    left = MC;
                end
                3'd2: begin
                    u = {32'd0, rs} * {32'd0, rt};
                    {phi, plo} = u;
                    left = MC;
                end
                3'd3: begin
                    if (rt != 0) begin
                        a = longint'($signed(rs));
                        b = longint'($signed(rt));
                        plo = 32'(a / b);
                        phi = 32'(a % b);
                    end else begin
                        phi = mhi;
                        plo = mlo;
                    end
                    left = DC;
                end
                3'd4: begin
                    if (rt != 0) begin
                        plo = rs / rt;
                        phi = rs % rt;
                    end else begin
                        phi = mhi;
                        plo = mlo;
                    end
                    left = DC;
                end
                3'd5: mhi = rs;
                3'd6: mlo = rs;
                default: ;
            endcase
        end
    endtask

    task automatic cyc(input logic rst, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt, input logic use_);
        @(negedge clk);
        reset = rst;
        bus.e_md_op = op;
        bus.e_rs = rs;
        bus.e_rt = rt;
        bus.d_md_use = use_;
        #1;
        if (valid) begin
            chk("model_busy", 32'(bus.busy), 32'(left > 0));
            chk("model_stall", 32'(bus.stall_req), 32'(use_ && (left > 0 || (op >= 3'd1 && op <= 3'd4))));
            chk("model_hi", bus.hi, mhi);
            chk("model_lo", bus.lo, mlo);
        end
        model_step(rst, op, rs, rt);
        if (rst) valid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] rrs, rrt;
        tbl[0] = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC};
        tbl[1] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
        tbl[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        tbl[3] = '{3'd5, 32'h00000011, 32'd0,        32'h00000011, 32'hFFFFFFFD, 0};
        tbl[4] = '{3'd6, 32'h00000022, 32'd0,        32'h00000011, 32'h00000022, 0};
        tbl[5] = '{3'd4, 32'd7,        32'd0,        32'h00000011, 32'h00000022, DC};
        tbl[6] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
        tbl[7] = '{3'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003, DC};
        tbl[8] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};
        tbl[9] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};

        cyc(1'b1, 3'd1, 32'd5, 32'd5, 1'b0);
        idle(1);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);

        for (int t = 0; t < 10; t++) begin
            cyc(1'b0, tbl[t].op, tbl[t].rs, tbl[t].rt, 1'b0);
            for (int k = 0; k < tbl[t].n; k++) begin
                idle(1);
                chk($sformatf("vec%0d_busy", t), 32'(bus.busy), 32'd1);
            end
            idle(1);
            chk($sformatf("vec%0d_done", t), 32'(bus.busy), 32'd0);
            chk($sformatf("vec%0d_hi", t), bus.hi, tbl[t].hi);
            chk($sformatf("vec%0d_lo", t), bus.lo, tbl[t].lo);
        end

        cyc(1'b0, 3'd3, 32'd100, 32'd7, 1'b1);
        chk("stall_start", 32'(bus.stall_req), 32'd1);
        for (int k = 0; k < DC; k++) begin
            cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
            chk("stall_busy", 32'(bus.stall_req), 32'd1);
        end
        cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        chk("stall_after", 32'(bus.stall_req), 32'd0);

        cyc(1'b0, 3'd1, 32'd9, 32'd9, 1'b0);
        idle(2);
        cyc(1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
        chk("abort_was_busy", 32'(bus.busy), 32'd1);
        idle(1);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        cyc(1'b0, 3'd6, 32'd5, 32'd0, 1'b0);
        idle(1);
        chk("abort_mtlo", bus.lo, 32'd5);

        cyc(1'b0, 3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
        idle(1);
        cyc(1'b0, 3'd6, 32'h77, 32'd0, 1'b0);
        idle(MC - 3);
        cyc(1'b0, 3'd5, 32'hAA, 32'd0, 1'b0);
        idle(1);
        chk("collide_busy", 32'(bus.busy), 32'd0);
        chk("collide_hi", bus.hi, 32'hFFFFFFFF);
        chk("collide_lo", bus.lo, 32'hFFFFFFFA);

        cyc(1'b1, 3'd2, 32'd3, 32'd3, 1'b0);
        idle(1);
        chk("rst_prio_busy", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 500; i++) begin
            rop = 3'($urandom_range(0, 7));
            rrs = $urandom;
            rrt = ($urandom_range(0, 5) == 0) ? 32'd0 :
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if ($urandom_range(0, 15) == 0) begin
                rrs = 32'h80000000;
                rrt = 32'hFFFFFFFF;
            end
            cyc(($urandom_range(0, 59) == 0), rop, rrs, rrt, 1'($urandom_range(0, 1)));
        end
        idle(DC + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
